sort_dram_writer: RTL and testbench
===================================

# sort_dram_writer

Write-back stage directly downstream of the `fpga_sort` merge tree. It accepts the sorted 512-bit record stream with a valid/ready handshake and buffers it in an internal FIFO. It drains the FIFO to DRAM through the `dst_*` Avalon-MM write master as aligned bursts. It raises `done` once every burst of the job has been acknowledged.

## Interface
Parameters:
- MAXBURST_LOG, 4, log2 of maximum burst length in beats (max burst 16).
- DRAM_ADDRSPACE, 64, byte-address width.
- DRAM_DATAWIDTH, 512, data beat width; bytes per beat BPB = DRAM_DATAWIDTH/8.
- FIFO_LOG, 5, log2 of FIFO depth in beats (32); must satisfy FIFO_LOG > MAXBURST_LOG.
- NUMW, 32, width of the beat count.

Ports:
- clock  in  1  single clock; all logic rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job start pulse; ignored unless state is IDLE.
- dst_addr  in  DRAM_ADDRSPACE  job base byte address, multiple of BPB; sampled on start.
- numbeats  in  NUMW  job length in beats; sampled on start.
- din  in  DRAM_DATAWIDTH  sorted data beat from sorter.
- din_valid  in  1  din qualifier.
- din_ready  out  1  high when FIFO not full; a beat transfers when din_valid & din_ready.
- dst_address  out  DRAM_ADDRSPACE  burst start address.
- dst_write  out  1  write request.
- dst_writedata  out  DRAM_DATAWIDTH  FIFO head.
- dst_byteenable  out  DRAM_DATAWIDTH/8  constant all ones.
- dst_burstcount  out  MAXBURST_LOG+1  beats in current burst.
- dst_read  out  1  constant 0.
- dst_waitrequest  in  1  slave stall.
- dst_writeack  in  1  one pulse per completed burst.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- Reset values:
  - dst_write=0, dst_address=0, dst_burstcount=0, busy=0, done=0.
  - din_ready=1; FIFO emptied.
  - All counters 0; state IDLE.
- Registers:
  - `addr`: next burst address.
  - `remain`: beats not yet issued.
  - `blen`: current burst length.
  - `bcnt`: beats left in the burst.
  - `outst`: bursts awaiting writeack.
- FIFO is independent of state. It accepts beats whenever not full, including in IDLE, so the sorter may run ahead of start.
- States:
  - IDLE: on start, latch addr=dst_addr and remain=numbeats. If numbeats==0 go to DONE, else go to ARM.
  - ARM: compute blen=min(remain, 2^MAXBURST_LOG). When FIFO count >= blen: drive dst_address=addr, dst_burstcount=blen, dst_write=1; set bcnt=blen; go to BURST.
  - BURST: each cycle with dst_write & !dst_waitrequest pops the FIFO and decrements bcnt.
    - dst_address and dst_burstcount stay constant for the whole burst.
    - dst_writedata always shows the FIFO head.
    - On the last beat accepted: addr += blen*BPB, remain -= blen, outst += 1.
    - Then: if remain becomes 0, deassert dst_write and go to DRAIN. Otherwise go to ARM and deassert dst_write for one cycle.
  - DRAIN: wait until outst==0, then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- A burst is issued only when all its beats are already in the FIFO, so dst_write never deasserts mid-burst.
- outst counter:
  - Width MAXBURST_LOG+2 bits.
  - writeack decrements it.
  - Writeack in the same cycle as a burst's last beat leaves it unchanged.
  - Writeack with outst==0 is ignored; it never wraps.
- Address arithmetic is modulo 2^DRAM_ADDRSPACE; wrap-around is not flagged.
- start while busy is ignored. Extra din beats beyond numbeats stay in the FIFO for the next job.
- resetn low mid-burst aborts the job immediately: all state returns to reset values and FIFO contents are discarded.

## Timing
- din handshake to FIFO count visible: 1 cycle.
- ARM to dst_write high: same cycle the count condition holds (registered outputs update at the next edge). Minimum FIFO-to-bus latency is 2 cycles.
- Full-rate burst: blen consecutive cycles with no waitrequest; waitrequest extends the burst 1 cycle per stalled cycle.
- Gap between bursts: 1 idle cycle (ARM).
- din_ready falls in the cycle after the FIFO reaches full. A pop and a push in the same cycle while full is allowed; count is unchanged.
- done rises 1 cycle after the cycle in which outst reaches 0 in DRAIN.
- With numbeats==0, done rises 2 cycles after start.

## Test plan
- numbeats=16, dst_addr=0x1000, 16 beats preloaded, no stalls, writeack 5 cycles after last beat -> one burst: address 0x1000, burstcount 16, 16 consecutive write cycles, data in input order; done pulses once.
- numbeats=37, dst_addr=0x0, data streamed 1 beat/cycle -> bursts 16/16/5 at addresses 0x0/0x400/0x800; done only after the 3rd writeack.
- numbeats=16, dst_waitrequest high on random cycles (~50%) -> address and burstcount held constant and each beat written exactly once in order; din_ready low while FIFO holds 32 beats.
- numbeats=0 -> no dst_write; done pulses 2 cycles after start; busy high for exactly those cycles.
- Writeack coincident with a burst's last beat, plus a spurious writeack in IDLE -> outst stays correct; done timing unaffected; no underflow.
- resetn asserted mid-burst after 7 beats -> all outputs at reset values immediately. A new job of 16 beats then completes cleanly, with no stale data written.

Source files
------------

// File: rtl/sort_dram_writer.sv
// rtl/sort_dram_writer.sv - sorted-record write-back: input FIFO drained to DRAM as aligned Avalon-MM bursts
module sort_dram_writer #(
    parameter int MAXBURST_LOG   = 4,
    parameter int DRAM_ADDRSPACE = 64,
    parameter int DRAM_DATAWIDTH = 512,
    parameter int FIFO_LOG       = 5,
    parameter int NUMW           = 32
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          start,
    input  logic [DRAM_ADDRSPACE-1:0]     dst_addr,
    input  logic [NUMW-1:0]               numbeats,
    input  logic [DRAM_DATAWIDTH-1:0]     din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic [DRAM_ADDRSPACE-1:0]     dst_address,
    output logic                          dst_write,
    output logic [DRAM_DATAWIDTH-1:0]     dst_writedata,
    output logic [DRAM_DATAWIDTH/8-1:0]   dst_byteenable,
    output logic [MAXBURST_LOG:0]         dst_burstcount,
    output logic                          dst_read,
    input  logic                          dst_waitrequest,
    input  logic                          dst_writeack,
    output logic                          busy,
    output logic                          done
);

    localparam int BPB   = DRAM_DATAWIDTH / 8;
    localparam int DEPTH = 1 << FIFO_LOG;
    localparam int BW    = MAXBURST_LOG + 1;
    localparam int OW    = MAXBURST_LOG + 2;
    localparam logic [MAXBURST_LOG:0] MAXB     = {1'b1, {MAXBURST_LOG{1'b0}}};
    localparam logic [FIFO_LOG:0]     FULL_CNT = {1'b1, {FIFO_LOG{1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_BURST, S_DRAIN, S_DONE} state_t;

    // FIFO storage and pointers
    logic [DRAM_DATAWIDTH-1:0] mem_q [DEPTH];
    logic [FIFO_LOG-1:0]       wr_ptr_q, rd_ptr_q;
    logic [FIFO_LOG:0]         cnt_q;
    logic                      push, pop;

    // Burst engine state and registered bus outputs
    state_t                    state_q;
    logic [DRAM_ADDRSPACE-1:0] addr_q;
    logic [NUMW-1:0]           remain_q;
    logic [MAXBURST_LOG:0]     blen_q;
    logic [MAXBURST_LOG:0]     bcnt_q;
    logic [OW-1:0]             outst_q, outst_d;
    logic                      dst_write_q;
    logic [DRAM_ADDRSPACE-1:0] dst_address_q;
    logic [MAXBURST_LOG:0]     dst_burstcount_q;
    logic                      busy_q, done_q;

    logic [MAXBURST_LOG:0]     blen_w;
    logic                      arm_go;
    logic                      last_beat;
    logic [NUMW-1:0]           remain_after;

    assign din_ready      = (cnt_q != FULL_CNT);
    assign push           = din_valid & din_ready;
    assign pop            = (state_q == S_BURST) & dst_write_q & ~dst_waitrequest;
    assign dst_writedata  = mem_q[rd_ptr_q];
    assign dst_byteenable = '1;
    assign dst_read       = 1'b0;
    assign dst_write      = dst_write_q;
    assign dst_address    = dst_address_q;
    assign dst_burstcount = dst_burstcount_q;
    assign busy           = busy_q;
    assign done           = done_q;

    // A burst is only armed once every one of its beats is already buffered,
    // so the write strobe never has to drop in the middle of a burst.
    assign blen_w       = (remain_q > NUMW'(MAXB)) ? MAXB : remain_q[MAXBURST_LOG:0];
    assign arm_go       = (state_q == S_ARM) && (cnt_q >= (FIFO_LOG+1)'(blen_w));
    assign last_beat    = pop && (bcnt_q == BW'(1));
    assign remain_after = remain_q - NUMW'(blen_q);

    // Data array has no reset; emptiness is tracked by the pointers alone
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + FIFO_LOG'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_LOG'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (FIFO_LOG+1)'(1);
                2'b01:   cnt_q <= cnt_q - (FIFO_LOG+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Outstanding-burst count: an ack coinciding with a burst's last beat cancels it, an ack with nothing pending is dropped
    always_comb begin
        outst_d = outst_q;
        if (last_beat && !dst_writeack) begin
            outst_d = outst_q + OW'(1);
        end else if (!last_beat && dst_writeack && (outst_q != '0)) begin
            outst_d = outst_q - OW'(1);
        end
    end

    // Job sequencer: IDLE -> ARM <-> BURST -> DRAIN -> DONE -> IDLE
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q          <= S_IDLE;
            addr_q           <= '0;
            remain_q         <= '0;
            blen_q           <= '0;
            bcnt_q           <= '0;
            outst_q          <= '0;
            dst_write_q      <= 1'b0;
            dst_address_q    <= '0;
            dst_burstcount_q <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            outst_q <= outst_d;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q   <= dst_addr;
                        remain_q <= numbeats;
                        busy_q   <= 1'b1;
                        state_q  <= (numbeats == '0) ? S_DONE : S_ARM;
                    end
                end
                S_ARM: begin
                    if (arm_go) begin
                        blen_q           <= blen_w;
                        bcnt_q           <= blen_w;
                        dst_address_q    <= addr_q;
                        dst_burstcount_q <= blen_w;
                        dst_write_q      <= 1'b1;
                        state_q          <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (pop) begin
                        bcnt_q <= bcnt_q - BW'(1);
                    end
                    if (last_beat) begin
                        addr_q      <= addr_q + DRAM_ADDRSPACE'(blen_q) * DRAM_ADDRSPACE'(BPB);
                        remain_q    <= remain_after;
                        dst_write_q <= 1'b0;
                        state_q     <= (remain_after == '0) ? S_DRAIN : S_ARM;
                    end
                end
                S_DRAIN: begin
                    if (outst_q == '0) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_dram_writer.sv
// tb/tb_sort_dram_writer.sv - scoreboard bench for sort_dram_writer
module tb_sort_dram_writer;

    logic         clock;
    logic         resetn;
    logic         start;
    logic [63:0]  dst_addr;
    logic [31:0]  numbeats;
    logic [511:0] din;
    logic         din_valid;
    logic         din_ready;
    logic [63:0]  dst_address;
    logic         dst_write;
    logic [511:0] dst_writedata;
    logic [63:0]  dst_byteenable;
    logic [4:0]   dst_burstcount;
    logic         dst_read;
    logic         dst_waitrequest;
    logic         dst_writeack;
    logic         busy;
    logic         done;

    sort_dram_writer dut (
        .clock          (clock),
        .resetn         (resetn),
        .start          (start),
        .dst_addr       (dst_addr),
        .numbeats       (numbeats),
        .din            (din),
        .din_valid      (din_valid),
        .din_ready      (din_ready),
        .dst_address    (dst_address),
        .dst_write      (dst_write),
        .dst_writedata  (dst_writedata),
        .dst_byteenable (dst_byteenable),
        .dst_burstcount (dst_burstcount),
        .dst_read       (dst_read),
        .dst_waitrequest(dst_waitrequest),
        .dst_writeack   (dst_writeack),
        .busy           (busy),
        .done           (done)
    );

    typedef struct {
        logic [63:0]  addr;
        logic [4:0]   bc;
        logic [511:0] data;
    } exp_t;

    exp_t sb[$];
    int   ack_due[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   next_seq = 0;
    int   exp_seq = 0;
    int   beats_seen = 0;
    int   bib = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;
    int   last_ack_cyc = -1;
    int   first_beat_cyc = 0;
    int   last_beat_cyc = 0;
    bit   stall_mode = 0;
    bit   coinc = 0;
    bit   spur = 0;

    function automatic logic [511:0] make_beat(int s);
        logic [31:0] w;
        w = 32'(s) ^ 32'hA5C3_0000;
        return {16{w}};
    endfunction

    task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // slave side: waitrequest pattern and writeack generation
    initial begin
        dst_waitrequest = 1'b0;
        dst_writeack    = 1'b0;
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            dst_waitrequest = stall_mode ? 1'($urandom_range(0, 1)) : 1'b0;
            dst_writeack    = 1'b0;
            if (spur) begin
                dst_writeack = 1'b1;
                spur = 0;
            end else if (coinc) begin
                if (dst_write && !dst_waitrequest && (bib == int'(dst_burstcount) - 1)) begin
                    dst_writeack = 1'b1;
                    last_ack_cyc = cyc;
                end
            end else if (ack_due.size() > 0 && ack_due[0] <= cyc) begin
                void'(ack_due.pop_front());
                dst_writeack = 1'b1;
                last_ack_cyc = cyc;
            end
        end
    end

    // monitor: pops the scoreboard on every accepted beat
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (dst_write) begin
                if (sb.size() == 0) begin
                    chk("write_when_none_expected", 512'(dst_write), 512'(0));
                end else begin
                    e = sb[0];
                    chk("address", 512'(dst_address), 512'(e.addr));
                    chk("burstcount", 512'(dst_burstcount), 512'(e.bc));
                    if (!dst_waitrequest) begin
                        chk("writedata", dst_writedata, e.data);
                        void'(sb.pop_front());
                        beats_seen++;
                        if (bib == 0) first_beat_cyc = cyc;
                        last_beat_cyc = cyc;
                        bib++;
                        if (bib == int'(e.bc)) begin
                            bib = 0;
                            if (!coinc) ack_due.push_back(cyc + 5);
                        end
                    end
                end
            end
        end
    end

    task automatic push_beats(int n);
        int got = 0;
        int guard = 0;
        bit acc;
        din_valid = 1'b1;
        while (got < n && guard < 2000) begin
            din = make_beat(next_seq);
            @(negedge clock);
            acc = din_ready;
            tick();
            if (acc) begin
                next_seq++;
                got++;
            end
            guard++;
        end
        din_valid = 1'b0;
        if (got < n) chk("push_timeout", 512'(got), 512'(n));
    endtask

    task automatic start_job(logic [63:0] a, int n);
        int k = 0;
        int bl;
        logic [63:0] aa;
        exp_t e;
        aa = a;
        while (k < n) begin
            bl = (n - k > 16) ? 16 : n - k;
            for (int i = 0; i < bl; i++) begin
                e.addr = aa;
                e.bc   = 5'(bl);
                e.data = make_beat(exp_seq);
                exp_seq++;
                sb.push_back(e);
            end
            aa = aa + 64'(bl * 64);
            k += bl;
        end
        dst_addr = a;
        numbeats = 32'(n);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(string name);
        int d0 = done_cnt;
        int g = 0;
        while (done_cnt == d0 && g < 3000) begin
            tick();
            g++;
        end
        chk(name, 512'(done_cnt - d0), 512'(1));
        repeat (4) tick();
        chk({name, "_once"}, 512'(done_cnt - d0), 512'(1));
        chk({name, "_sb_empty"}, 512'(sb.size()), 512'(0));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int d0;
        int tgt;
        int g;
        resetn    = 1'b0;
        start     = 1'b0;
        dst_addr  = '0;
        numbeats  = '0;
        din       = '0;
        din_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_write", 512'(dst_write), 512'(0));
        chk("rst_address", 512'(dst_address), 512'(0));
        chk("rst_burstcount", 512'(dst_burstcount), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_din_ready", 512'(din_ready), 512'(1));
        chk("rst_read", 512'(dst_read), 512'(0));
        chk("rst_byteenable", 512'(dst_byteenable), 512'(64'hFFFF_FFFF_FFFF_FFFF));
        tick();
        resetn = 1'b1;
        repeat (2) tick();

        // single preloaded burst
        push_beats(16);
        start_job(64'h1000, 16);
        wait_done("t1_done");
        chk("t1_consecutive", 512'(last_beat_cyc - first_beat_cyc), 512'(15));
        chk("t1_done_after_ack", 512'(done_cyc > last_ack_cyc), 512'(1));

        // streamed 37 beats: bursts 16/16/5
        fork
            start_job(64'h0, 37);
            push_beats(37);
        join
        wait_done("t2_done");
        chk("t2_done_after_ack", 512'(done_cyc > last_ack_cyc), 512'(1));

        // full FIFO then a stalled burst; 16 beats remain buffered afterwards
        push_beats(32);
        chk("t3_din_ready_full", 512'(din_ready), 512'(0));
        stall_mode = 1;
        start_job(64'h2000, 16);
        wait_done("t3_done");
        stall_mode = 0;
        chk("t3_din_ready_after", 512'(din_ready), 512'(1));

        // zero-length job
        d0 = done_cnt;
        dst_addr = 64'h9000;
        numbeats = 32'd0;
        start    = 1'b1;
        @(negedge clock);
        chk("t4_busy_s0", 512'(busy), 512'(0));
        tick();
        start = 1'b0;
        @(negedge clock);
        chk("t4_busy_s1", 512'(busy), 512'(1));
        chk("t4_done_s1", 512'(done), 512'(0));
        @(negedge clock);
        chk("t4_done_s2", 512'(done), 512'(1));
        chk("t4_busy_s2", 512'(busy), 512'(0));
        @(negedge clock);
        chk("t4_done_s3", 512'(done), 512'(0));
        tick();
        chk("t4_done_count", 512'(done_cnt - d0), 512'(1));

        // spurious ack in idle, then acks coincident with last beats
        spur = 1;
        repeat (3) tick();
        coinc = 1;
        start_job(64'h3000, 16);
        wait_done("t5_coinc_done");
        coinc = 0;
        spur = 1;
        repeat (2) tick();
        push_beats(5);
        start_job(64'h3400, 5);
        wait_done("t5_spur_done");
        chk("t5_done_after_ack", 512'(done_cyc > last_ack_cyc), 512'(1));

        // reset after 7 beats of a burst, then a clean job
        push_beats(16);
        tgt = beats_seen + 7;
        start_job(64'h5000, 16);
        g = 0;
        while (beats_seen < tgt && g < 200) begin
            @(negedge clock);
            #1;
            g++;
        end
        chk("t6_reached_7_beats", 512'(beats_seen >= tgt), 512'(1));
        @(posedge clock);
        #1;
        resetn = 1'b0;
        #1;
        chk("t6_rst_write", 512'(dst_write), 512'(0));
        chk("t6_rst_address", 512'(dst_address), 512'(0));
        chk("t6_rst_burstcount", 512'(dst_burstcount), 512'(0));
        chk("t6_rst_busy", 512'(busy), 512'(0));
        chk("t6_rst_done", 512'(done), 512'(0));
        chk("t6_rst_din_ready", 512'(din_ready), 512'(1));
        sb.delete();
        ack_due.delete();
        bib = 0;
        exp_seq = next_seq;
        tick();
        tick();
        resetn = 1'b1;
        tick();
        push_beats(16);
        start_job(64'h6000, 16);
        wait_done("t6_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
